// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with HI/LO result registers.
// One operation takes 32 RUN cycles of radix-2 iteration, then a
// one-cycle DONE pulse; HI/LO may also be written directly when idle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic               isDiv;
  logic               isSigned;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH-1:0]   aInMag;
  logic [WIDTH-1:0]   bInMag;
  logic [2*WIDTH-1:0] workInit;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] stepNext;
  logic               resNeg;
  logic [2*WIDTH-1:0] mulRes;
  logic [WIDTH-1:0]   quotRes;
  logic [WIDTH-1:0]   remRes;
  logic               divZero;

  // Magnitude of a value, treating it as two's complement only when signed.
  function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Datapath: one shift-add or restoring-divide step on the working register,
  // plus the sign fix-up applied to the value produced by the final step.
  always_comb begin
    isDiv    = op_q[1];
    isSigned = op_q[0];
    aMag     = magOf(a_q, isSigned);
    bMag     = magOf(b_q, isSigned);
    aInMag   = magOf(a, op[0]);
    bInMag   = magOf(b, op[0]);

    // Multiply keeps {partial product, remaining multiplier}; divide keeps
    // {partial remainder, dividend bits shifting into quotient}.
    workInit = op[1] ? {{WIDTH{1'b0}}, aInMag} : {{WIDTH{1'b0}}, bInMag};

    mulSum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, aMag} : '0);
    mulNext  = {mulSum, work_q[WIDTH-1:1]};

    divShift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, bMag};
    divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};

    stepNext = isDiv ? divNext : mulNext;

    resNeg   = isSigned && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    mulRes   = resNeg ? -stepNext : stepNext;
    quotRes  = resNeg ? -stepNext[WIDTH-1:0] : stepNext[WIDTH-1:0];
    remRes   = (isSigned && a_q[WIDTH-1]) ? -stepNext[2*WIDTH-1:WIDTH]
                                          : stepNext[2*WIDTH-1:WIDTH];
    divZero  = (b_q == '0);
  end

  // Control: accept work in IDLE/DONE, iterate in RUN, publish on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (we_hi) hi_d = wd;
        if (we_lo) lo_d = wd;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          work_d  = workInit;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d = stepNext;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!isDiv) begin
            hi_d = mulRes[2*WIDTH-1:WIDTH];
            lo_d = mulRes[WIDTH-1:0];
          end else if (divZero) begin
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = remRes;
            lo_d = quotRes;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign dz   = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: expected HI/LO/dz are pushed into a scoreboard
// when an operation is issued and popped by a monitor on each done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  logic [31:0] expHi;
  logic [31:0] expLo;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    longint sx, sy, q, r;
    e.dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = 64'(x) * 64'(y);
      2'b01: p = 64'(sx * sy);
      default: p = '0;
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    if (o[1]) begin
      if (y == 32'd0) begin
        e.hi = x;
        e.lo = 32'hFFFF_FFFF;
        e.dz = 1'b1;
      end else if (o == 2'b10) begin
        e.lo = x / y;
        e.hi = x % y;
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000;
        e.hi = 32'h0;
      end else begin
        q = sx / sy;
        r = sx % sy;
        e.lo = 32'(q);
        e.hi = 32'(r);
      end
    end
    return e;
  endfunction

  // Monitor: compare results at each done pulse; dz must stay low elsewhere.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("result_hi", 64'(hi), 64'(e.hi));
          checkOutput("result_lo", 64'(lo), 64'(e.lo));
          checkOutput("result_dz", 64'(dz), 64'(e.dz));
        end
      end else begin
        checkOutput("dz_outside_done", 64'(dz), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it through 32 RUN cycles to DONE.
  // Returns at the falling edge of the DONE cycle so a caller may chain.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit noisy, input bit wrAtStart);
    exp_t e;
    int badBusy;
    logic [31:0] w;
    e = model(o, x, y);
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (wrAtStart) begin
      w = $urandom;
      we_hi = 1'b1;
      wd = w;
      expHi = w;
    end
    tick();
    start = 1'b0;
    we_hi = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    badBusy = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) badBusy++;
      if (i == 1 && wrAtStart) checkOutput("hi_write_with_start", 64'(hi), 64'(expHi));
      if (noisy && i == 5) begin
        start = 1'b1;
        we_lo = 1'b1;
        we_hi = 1'b1;
        wd = $urandom;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
      end
      if (noisy && i == 6) begin
        start = 1'b0;
        we_lo = 1'b0;
        we_hi = 1'b0;
        checkOutput("run_write_ignored_lo", 64'(lo), 64'(expLo));
        checkOutput("run_write_ignored_hi", 64'(hi), 64'(expHi));
      end
      tick();
    end
    @(negedge clk);
    checkOutput("busy_cycles_1_32_bad", 64'(badBusy), 64'(0));
    checkOutput("done_at_cycle_33", 64'(done), 64'(1));
    checkOutput("busy_low_in_done", 64'(busy), 64'(0));
    expHi = e.hi;
    expLo = e.lo;
  endtask

  // Start an operation and reset it at cycle rstCycle of the run.
  task automatic abortOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int rstCycle);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    repeat (rstCycle - 1) tick();
    rst = 1'b1;
    start = 1'b1;
    we_lo = 1'b1;
    we_hi = 1'b1;
    wd = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    start = 1'b0;
    we_lo = 1'b0;
    we_hi = 1'b0;
    expHi = '0;
    expLo = '0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_done", 64'(done), 64'(0));
    checkOutput("abort_hi", 64'(hi), 64'(0));
    checkOutput("abort_lo", 64'(lo), 64'(0));
    repeat (40) tick();
    checkOutput("abort_stays_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    bit n;
    bit wr;
    logic [1:0] ro;
    logic [31:0] rx, ry;
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    wd = '0;
    expHi = '0;
    expLo = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'(0));
    checkOutput("reset_lo", 64'(lo), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_dz", 64'(dz), 64'(0));
    tick();

    // Direct write in IDLE.
    we_lo = 1'b1;
    wd = 32'h1234_5678;
    tick();
    we_lo = 1'b0;
    expLo = 32'h1234_5678;
    @(negedge clk);
    checkOutput("idle_write_lo", 64'(lo), 64'(32'h1234_5678));
    we_hi = 1'b1;
    wd = 32'hCAFE_0001;
    tick();
    we_hi = 1'b0;
    expHi = 32'hCAFE_0001;
    @(negedge clk);
    checkOutput("idle_write_hi", 64'(hi), 64'(32'hCAFE_0001));
    tick();

    // Directed cases; the first has a write attempt and a start during RUN.
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    applyStimulus(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    applyStimulus(2'b10, 32'h64, 32'd0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("dz_cleared_after_done", 64'(dz), 64'(0));
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1);
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    tick();

    // Direct write while in DONE.
    applyStimulus(2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
    we_lo = 1'b1;
    wd = 32'h0BAD_F00D;
    tick();
    we_lo = 1'b0;
    expLo = 32'h0BAD_F00D;
    @(negedge clk);
    checkOutput("done_write_lo", 64'(lo), 64'(32'h0BAD_F00D));
    tick();

    // Reset in the middle of a run.
    abortOp(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Randomized operations with random gaps, noise and same-edge writes.
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 15));
        2: rx = 32'h8000_0000;
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      n = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) == 0);
      applyStimulus(ro, rx, ry, n, wr);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end
    repeat (3) tick();

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; all values below assume 32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when accepting (REQ-010).
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  32  multiplicand / dividend.
REQ-007 SHALL have port b  input  32  multiplier / divisor.
REQ-008 SHALL have ports we_hi, we_lo  input  1 each, and wd  input  32: direct HI/LO write (mthi/mtlo).
REQ-009 SHALL have ports hi, lo  output  32 each; busy  output  1; done  output  1; dz  output  1 (divide-by-zero flag).

Function
REQ-010 SHALL implement states IDLE, RUN, DONE; start is accepted in IDLE or DONE, ignored in RUN.
REQ-011 Accepting start (cycle 0 edge) SHALL latch op, a, b internally; later changes to a/b/op SHALL not affect the result.
REQ-012 Accepted start SHALL move to RUN with 5-bit iteration counter cleared; RUN lasts exactly 32 cycles (cycles 1..32).
REQ-013 At the edge ending cycle 32, hi/lo SHALL load the final result and state SHALL move to DONE.
REQ-014 busy SHALL be 1 exactly in RUN (cycles 1..32); done SHALL be 1 exactly in DONE (cycle 33, one-cycle pulse).
REQ-015 DONE SHALL go to IDLE on next edge, or to RUN if start is high then (back-to-back, no bubble).
REQ-016 Multiply SHALL use radix-2 shift-add on 32-bit magnitudes, 64-bit product: hi = product[63:32], lo = product[31:0].
REQ-017 MULT SHALL take magnitudes of a and b and two's-complement negate the 64-bit product when sign(a) != sign(b).
REQ-018 Divide SHALL use radix-2 restoring division on magnitudes: lo = quotient, hi = remainder.
REQ-019 DIV SHALL negate quotient when sign(a) != sign(b), and give remainder the sign of a.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0, no flag.
REQ-021 Divide with b = 0 SHALL still take 32 RUN cycles, give lo = 0xFFFFFFFF and hi = a (unsigned and signed alike), and set dz = 1 during DONE.
REQ-022 dz SHALL be 0 in all states other than DONE-after-divide-by-zero.
REQ-023 we_hi/we_lo in IDLE or DONE SHALL write wd into hi/lo at that edge; in RUN they SHALL be ignored.
REQ-024 Direct write and accepted start on the same edge SHALL both take effect; the operation result later overwrites hi/lo.
REQ-025 hi/lo SHALL hold their value in all cycles except REQ-013, REQ-023, and reset.
REQ-026 Counter SHALL not wrap inside RUN; the 32nd iteration's terminal count forces the exit to DONE.

Reset
REQ-027 rst high at an edge SHALL force IDLE, hi = 0, lo = 0, busy = 0, done = 0, dz = 0, counter = 0, latched operands = 0, regardless of state.
REQ-028 Reset mid-RUN SHALL discard the operation; no done pulse SHALL follow.
REQ-029 rst SHALL override start and we_hi/we_lo on the same edge.

Verification
REQ-030 MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> busy cycles 1..32, done at cycle 33, hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-031 MULT a = 0xFFFFFFFD (-3), b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; a/b changed during RUN do not alter the result.
REQ-032 DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100 / 7 -> lo = 14, hi = 2.
REQ-033 DIVU a = 0x64, b = 0 -> lo = 0xFFFFFFFF, hi = 0x64, dz = 1 for cycle 33 only.
REQ-034 Start in RUN ignored; start held during DONE -> busy again next cycle; rst at cycle 10 -> busy = 0, hi = lo = 0 next cycle, no done.
REQ-035 we_lo = 1, wd = 0x12345678 in IDLE -> lo = 0x12345678 next cycle; same write during RUN -> lo unchanged.
